// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// The state enum is shared so the top level and any debug logic agree on the encoding.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        DATA,
        WRITE,
        CHK,
        WAIT_EN,
        RUN,
        ERR
    } state_t;

    // States in which the loader pulls a byte off the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == IDLE) || (s == CNT_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word shift register.
// word/word_done describe the word completed by the byte presented this cycle.
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(LANES);

    logic [8*(LANES-1)-1:0] lane_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [8*LANES-1:0]     taps;

    // Lane 0 is the incoming byte; older bytes sit in higher lanes so the first byte lands in the MSB.
    assign taps[7:0] = byte_in;
    generate
        for (genvar gi = 1; gi < LANES; gi++) begin : g_tap
            assign taps[8*gi +: 8] = lane_reg[8*(gi-1) +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_reg <= '0;
            idx_reg  <= '0;
        end else if (byte_valid) begin
            lane_reg <= taps[8*(LANES-1)-1:0];
            idx_reg  <= idx_reg + IDX_W'(1);
        end
    end

    assign word      = taps;
    assign word_done = byte_valid && (idx_reg == IDX_W'(LANES - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the Stage1 instruction memory: writes N words from
// address 0, verifies the XOR checksum, then releases ProgMode and En_Pipeline.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int EN_DELAY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] Instruction_addr,
    output logic [DATA_W-1:0] Instruction_Data,
    output logic              Instr_we,
    output logic              ProgMode,
    output logic              En_Pipeline,
    output logic              load_err
);
    localparam int         CNT_W   = 12;
    localparam logic [3:0] EN_LAST = 4'(EN_DELAY - 1);

    state_t            state_reg, state_next;
    logic              ready_reg;
    logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
    logic [CNT_W-1:0]  words_left_reg, words_left_next;
    logic [7:0]        xor_reg, xor_next;
    logic [3:0]        cnt_hi_reg, cnt_hi_next;
    logic [3:0]        delay_reg, delay_next;
    logic [ADDR_W-1:0] iaddr_reg, iaddr_next;
    logic [DATA_W-1:0] idata_reg, idata_next;
    logic              we_reg, we_next;
    logic              prog_reg, prog_next;
    logic              en_reg, en_next;
    logic              err_reg, err_next;

    logic              xfer;
    logic              byte_valid;
    logic [DATA_W-1:0] asm_word;
    logic              word_done;
    logic [CNT_W-1:0]  word_count;

    assign xfer       = rx_valid && ready_reg;
    assign byte_valid = xfer && (state_reg == DATA) && !reload;
    assign word_count = {cnt_hi_reg, rx_data};

    word_assembler #(
        .DATA_W(DATA_W)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (reload),
        .byte_valid(byte_valid),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            addr_cnt_reg   <= '0;
            words_left_reg <= '0;
            xor_reg        <= '0;
            cnt_hi_reg     <= '0;
            delay_reg      <= '0;
            iaddr_reg      <= '0;
            idata_reg      <= '0;
            we_reg         <= 1'b0;
            prog_reg       <= 1'b0;
            en_reg         <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= accepts_bytes(state_next);
            addr_cnt_reg   <= addr_cnt_next;
            words_left_reg <= words_left_next;
            xor_reg        <= xor_next;
            cnt_hi_reg     <= cnt_hi_next;
            delay_reg      <= delay_next;
            iaddr_reg      <= iaddr_next;
            idata_reg      <= idata_next;
            we_reg         <= we_next;
            prog_reg       <= prog_next;
            en_reg         <= en_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_cnt_next   = addr_cnt_reg;
        words_left_next = words_left_reg;
        xor_next        = xor_reg;
        cnt_hi_next     = cnt_hi_reg;
        delay_next      = delay_reg;
        iaddr_next      = iaddr_reg;
        idata_next      = idata_reg;
        we_next         = 1'b0;
        prog_next       = prog_reg;
        en_next         = en_reg;
        err_next        = err_reg;

        // reload wins over any byte presented in the same cycle.
        if (reload) begin
            state_next      = IDLE;
            addr_cnt_next   = '0;
            words_left_next = '0;
            xor_next        = '0;
            delay_next      = '0;
            prog_next       = 1'b0;
            en_next         = 1'b0;
            err_next        = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        cnt_hi_next = rx_data[3:0];
                        xor_next    = xor_reg ^ rx_data;
                        state_next  = CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (xfer) begin
                        xor_next        = xor_reg ^ rx_data;
                        words_left_next = word_count;
                        state_next      = (word_count == '0) ? CHK : DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        xor_next = xor_reg ^ rx_data;
                    end
                    if (word_done) begin
                        iaddr_next      = addr_cnt_reg;
                        idata_next      = asm_word;
                        we_next         = 1'b1;
                        words_left_next = words_left_reg - CNT_W'(1);
                        state_next      = WRITE;
                    end
                end
                WRITE: begin
                    addr_cnt_next = addr_cnt_reg + ADDR_W'(1);
                    state_next    = (words_left_reg == '0) ? CHK : DATA;
                end
                CHK: begin
                    if (xfer) begin
                        xor_next = xor_reg ^ rx_data;
                        if ((xor_reg ^ rx_data) == 8'h00) begin
                            prog_next  = 1'b1;
                            delay_next = '0;
                            state_next = WAIT_EN;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ERR;
                        end
                    end
                end
                WAIT_EN: begin
                    if (delay_reg == EN_LAST) begin
                        en_next    = 1'b1;
                        state_next = RUN;
                    end else begin
                        delay_next = delay_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    assign rx_ready         = ready_reg;
    assign Instruction_addr = iaddr_reg;
    assign Instruction_Data = idata_reg;
    assign Instr_we         = we_reg;
    assign ProgMode         = prog_reg;
    assign En_Pipeline      = en_reg;
    assign load_err         = err_reg;

endmodule
